alu_issue_seq: RTL and testbench
================================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter: W, default 16, datapath width; must match the ALU operand width.
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  1  instruction request valid.
REQ-005 Port: req_ready  output  1  block can accept a request.
REQ-006 Port: req_opcode  input  6  MIPS opcode field.
REQ-007 Port: req_funct  input  6  MIPS funct field; used only when opcode=0x00.
REQ-008 Port: req_rs  input  W  first operand value.
REQ-009 Port: req_rt  input  W  second operand value for R-type and beq.
REQ-010 Port: req_imm  input  W  immediate, already W bits; used directly.
REQ-011 Port: alu_x, alu_y  output  W each  registered operands to the ALU.
REQ-012 Port: alu_op  output  3  ALU op: add=000, and=001, or=010, slt=011, sub/beq=100.
REQ-013 Port: alu_cin  output  1  ALU carry-in; always 0, since subtract is selected by alu_op[2].
REQ-014 Port: alu_res  input  W  ALU result.
REQ-015 Port: alu_zero, alu_ov  input  1 each  ALU zero and overflow flags.
REQ-016 Port: rsp_valid  output  1  response valid.
REQ-017 Port: rsp_ready  input  1  consumer accepts the response.
REQ-018 Port: rsp_data  output  W  captured result.
REQ-019 Port: rsp_zero, rsp_ov, rsp_taken, rsp_err  output  1 each  captured flags.
REQ-020 Port: ops_done  output  16  count of completed responses; wraps.

Function
REQ-021 Decode: R-type funct 0x20 add=000, 0x22 sub=100, 0x24 and=001, 0x25 or=010, 0x2A slt=011.
REQ-022 Decode: opcode 0x08 addi=000, 0x0C andi=001, 0x0D ori=010, 0x0A slti=011, 0x04 beq=100.
REQ-023 Decode: any other opcode/funct combination is illegal.
REQ-024 Operand y: req_rt for R-type and beq; req_imm for the other I-types. Operand x: always req_rs.
REQ-025 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-026 req_ready = 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-027 IDLE, legal request accepted: register alu_x, alu_y and alu_op, then go to ISSUE.
REQ-028 ISSUE: one settle cycle with operands held; then go to CAPTURE.
REQ-029 CAPTURE: latch the response outputs as follows, then go to RESP.
  - rsp_data = alu_res; rsp_zero = alu_zero.
  - rsp_ov = alu_ov only for add, addi and sub; otherwise 0.
  - rsp_taken = beq AND alu_zero.
  - rsp_err = rsp_ov.
REQ-030 IDLE, illegal request accepted: go directly to RESP with rsp_data=0, rsp_err=1 and all other flags 0; alu_* are left unchanged.
REQ-031 RESP: rsp_valid=1; all rsp_* outputs are held stable until rsp_ready=1.
REQ-032 RESP with rsp_ready=1: go to IDLE, increment ops_done by 1 (mod 2^16), and deassert rsp_valid next cycle.
REQ-033 Latency, accept edge to rsp_valid=1: 3 cycles for a legal op, 1 cycle for an illegal op.
REQ-034 Throughput: at most one op in flight; the next request can be accepted the cycle after the response handshake.
REQ-035 rsp_valid = 0 in IDLE, ISSUE and CAPTURE.
REQ-036 Requests presented outside IDLE are ignored and not captured.
REQ-037 ops_done at 0xFFFF wraps to 0x0000 on the next completion.

Reset
REQ-038 While rst=1 at a clock edge: state=IDLE, and these outputs are cleared:
  - alu_x, alu_y, alu_op, rsp_data all 0.
  - all rsp flags 0; rsp_valid 0.
  - ops_done 0.
REQ-039 rst asserted in any state, including mid-operation, discards the op with no response and no count; req_ready=1 on the first cycle after rst deasserts.

Verification
REQ-040 add: rs=0x0003, rt=0x0004, funct 0x20 -> alu_op=000; rsp_valid at +3 cycles; rsp_data=0x0007; all flags 0; ops_done=1 after handshake.
REQ-041 beq: rs=rt=0x1234, opcode 0x04 -> alu_op=100; rsp_zero=1; rsp_taken=1; rsp_data=0x0000.
REQ-042 Overflow: addi rs=0x7FFF, imm=0x0001 -> rsp_data=0x8000; rsp_ov=1; rsp_err=1. Same operands with ori -> rsp_ov=0.
REQ-043 Illegal: opcode 0x3F -> rsp_valid at +1 cycle; rsp_err=1; rsp_data=0; alu_* unchanged.
REQ-044 Back-pressure and reset: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0. Then assert rst during ISSUE of the next op -> no response, ops_done unchanged from reset value 0, req_ready=1 the cycle after rst drops.
REQ-045 Wrap: preload 65535 completions (or force the counter) -> next completion yields ops_done=0x0000.

Source files
------------

// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: request, ALU operand/result and response signals of the issue sequencer
interface alu_issue_seq_if #(
    parameter int W = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_opcode;
    logic [5:0]   req_funct;
    logic [W-1:0] req_rs;
    logic [W-1:0] req_rt;
    logic [W-1:0] req_imm;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic [2:0]   alu_op;
    logic         alu_cin;
    logic [W-1:0] alu_res;
    logic         alu_zero;
    logic         alu_ov;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_ov;
    logic         rsp_taken;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm,
        input  alu_res, alu_zero, alu_ov, rsp_ready,
        output req_ready, alu_x, alu_y, alu_op, alu_cin,
        output rsp_valid, rsp_data, rsp_zero, rsp_ov, rsp_taken, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm,
        output alu_res, alu_zero, alu_ov, rsp_ready,
        input  req_ready, alu_x, alu_y, alu_op, alu_cin,
        input  rsp_valid, rsp_data, rsp_zero, rsp_ov, rsp_taken, rsp_err
    );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: decodes one MIPS ALU instruction at a time, drives an external ALU and returns a handshaked response
module alu_issue_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_seq_if.slave bus,
    output logic [15:0]    ops_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d, rsp_data_q, rsp_data_d;
    logic [2:0]   alu_op_q, alu_op_d;
    logic         beq_q, beq_d;
    logic         rsp_zero_q, rsp_zero_d, rsp_ov_q, rsp_ov_d;
    logic         rsp_taken_q, rsp_taken_d, rsp_err_q, rsp_err_d;
    logic [15:0]  ops_done_q, ops_done_d;
    logic         legal, use_imm, dec_beq, accept, ov_en;
    logic [2:0]   dec_op;

    always_comb begin
        legal   = 1'b1;
        use_imm = 1'b0;
        dec_beq = 1'b0;
        dec_op  = 3'b000;
        if (bus.req_opcode == 6'h00) begin
            case (bus.req_funct)
                6'h20:   dec_op = 3'b000;
                6'h22:   dec_op = 3'b100;
                6'h24:   dec_op = 3'b001;
                6'h25:   dec_op = 3'b010;
                6'h2A:   dec_op = 3'b011;
                default: legal = 1'b0;
            endcase
        end else begin
            use_imm = 1'b1;
            case (bus.req_opcode)
                6'h08:   dec_op = 3'b000;
                6'h0C:   dec_op = 3'b001;
                6'h0D:   dec_op = 3'b010;
                6'h0A:   dec_op = 3'b011;
                6'h04: begin
                    dec_op  = 3'b100;
                    use_imm = 1'b0;
                    dec_beq = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    assign accept = bus.req_valid && state_q == IDLE;
    // alu_op 100 is shared by sub and beq; only the arithmetic ops may report overflow
    assign ov_en  = alu_op_q == 3'b000 || (alu_op_q == 3'b100 && !beq_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_op_q    <= '0;
            beq_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ov_q    <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_op_q    <= alu_op_d;
            beq_q       <= beq_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ov_q    <= rsp_ov_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_err_q   <= rsp_err_d;
            ops_done_q  <= ops_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (legal ? ISSUE : RESP) : IDLE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_op_d    = alu_op_q;
        beq_d       = beq_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ov_d    = rsp_ov_q;
        rsp_taken_d = rsp_taken_q;
        rsp_err_d   = rsp_err_q;
        ops_done_d  = ops_done_q;
        if (accept && legal) begin
            alu_x_d  = bus.req_rs;
            alu_y_d  = use_imm ? bus.req_imm : bus.req_rt;
            alu_op_d = dec_op;
            beq_d    = dec_beq;
        end
        if (accept && !legal) begin
            rsp_data_d  = '0;
            rsp_zero_d  = 1'b0;
            rsp_ov_d    = 1'b0;
            rsp_taken_d = 1'b0;
            rsp_err_d   = 1'b1;
        end
        if (state_q == CAPTURE) begin
            rsp_data_d  = bus.alu_res;
            rsp_zero_d  = bus.alu_zero;
            rsp_ov_d    = ov_en && bus.alu_ov;
            rsp_taken_d = beq_q && bus.alu_zero;
            rsp_err_d   = ov_en && bus.alu_ov;
        end
        if (state_q == RESP && bus.rsp_ready)
            ops_done_d = ops_done_q + 16'd1;
    end

    always_comb begin
        bus.req_ready = state_q == IDLE;
        bus.rsp_valid = state_q == RESP;
    end

    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_cin   = 1'b0;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_ov    = rsp_ov_q;
    assign bus.rsp_taken = rsp_taken_q;
    assign bus.rsp_err   = rsp_err_q;
    assign ops_done      = ops_done_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed and randomized checks of alu_issue_seq against an instruction-level reference model
module tb_alu_issue_seq;
    localparam int W = 16;

    typedef struct packed {
        logic         rdy;
        int           lat;
        logic [W-1:0] ax;
        logic [W-1:0] ay;
        logic [2:0]   aop;
        logic [W-1:0] data;
        logic [3:0]   fl;
        logic         stable;
    } obs_t;

    typedef struct packed {
        logic         legal;
        logic [2:0]   op;
        logic [W-1:0] y;
        logic [W-1:0] data;
        logic [3:0]   fl;
    } ref_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  ops_done;
    int           n_run = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_x = '0;
    logic [W-1:0] exp_y = '0;
    logic [2:0]   exp_op = '0;
    logic [15:0]  exp_cnt = '0;
    logic [W-1:0] alu_sum, alu_dif;

    alu_issue_seq_if #(.W(W)) bus ();
    alu_issue_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus), .ops_done(ops_done));

    always #5 clk = ~clk;

    // external ALU; reports overflow even for logic ops so the sequencer's masking is exercised
    assign alu_sum = bus.alu_x + bus.alu_y;
    assign alu_dif = bus.alu_x - bus.alu_y;
    assign bus.alu_res = bus.alu_op == 3'b000 ? alu_sum :
                         bus.alu_op == 3'b001 ? (bus.alu_x & bus.alu_y) :
                         bus.alu_op == 3'b010 ? (bus.alu_x | bus.alu_y) :
                         bus.alu_op == 3'b011 ? {{(W-1){1'b0}}, $signed(bus.alu_x) < $signed(bus.alu_y)} : alu_dif;
    assign bus.alu_zero = bus.alu_res == '0;
    assign bus.alu_ov = (bus.alu_op[2] || bus.alu_op == 3'b011) ?
                        (bus.alu_x[W-1] != bus.alu_y[W-1] && alu_dif[W-1] != bus.alu_x[W-1]) :
                        (bus.alu_x[W-1] == bus.alu_y[W-1] && alu_sum[W-1] != bus.alu_x[W-1]);

    // kinds: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 beq; +10 means the immediate replaces rt
    function automatic ref_t ref_op(input logic [5:0] opc, input logic [5:0] fn, input logic [W-1:0] rs,
                                    input logic [W-1:0] rt, input logic [W-1:0] imm);
        ref_t   e;
        int     kind;
        int     k;
        longint s;
        logic   v;
        if (opc == 6'h00)
            kind = fn == 6'h20 ? 0 : fn == 6'h22 ? 1 : fn == 6'h24 ? 2 : fn == 6'h25 ? 3 : fn == 6'h2A ? 4 : -1;
        else
            kind = opc == 6'h08 ? 10 : opc == 6'h0C ? 12 : opc == 6'h0D ? 13 : opc == 6'h0A ? 14 : opc == 6'h04 ? 5 : -1;
        k = kind % 10;
        e.legal = kind >= 0;
        e.y = kind >= 10 ? imm : rt;
        e.op = k == 0 ? 3'b000 : k == 2 ? 3'b001 : k == 3 ? 3'b010 : k == 4 ? 3'b011 : 3'b100;
        s = (k == 1 || k == 5) ? longint'($signed(rs)) - longint'($signed(e.y)) : longint'($signed(rs)) + longint'($signed(e.y));
        v = s > longint'(2 ** (W - 1) - 1) || s < -longint'(2 ** (W - 1));
        e.data = !e.legal ? '0 : k == 2 ? (rs & e.y) : k == 3 ? (rs | e.y) :
                 k == 4 ? {{(W-1){1'b0}}, $signed(rs) < $signed(e.y)} : W'(s);
        e.fl = !e.legal ? 4'b0001 : {e.data == '0, v && k <= 1, k == 5 && e.data == '0, v && k <= 1};
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        int c;
        c = $urandom_range(0, 5);
        return c == 0 ? 16'h0000 : c == 1 ? 16'h7FFF : c == 2 ? 16'h8000 : c == 3 ? 16'hFFFF : c == 4 ? 16'h0001 : W'($urandom);
    endfunction

    // presents one request at the current negedge, observes it to the response handshake and returns at a negedge
    task automatic run_op(input logic [5:0] opc, input logic [5:0] fn, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic [W-1:0] imm, input int hold, input logic junk, output obs_t o);
        o = '0;
        o.rdy = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.req_opcode = opc;
        bus.req_funct = fn;
        bus.req_rs = rs;
        bus.req_rt = rt;
        bus.req_imm = imm;
        @(posedge clk);
        @(negedge clk);
        o.lat = 1;
        bus.req_valid = junk;
        bus.req_opcode = 6'h00;
        bus.req_funct = 6'h20;
        bus.req_rs = W'($urandom);
        bus.req_rt = W'($urandom);
        bus.req_imm = W'($urandom);
        o.ax = bus.alu_x;
        o.ay = bus.alu_y;
        o.aop = bus.alu_op;
        while (bus.rsp_valid !== 1'b1 && o.lat < 8) begin
            @(negedge clk);
            o.lat = o.lat + 1;
        end
        bus.req_valid = 1'b0;
        o.data = bus.rsp_data;
        o.fl = {bus.rsp_zero, bus.rsp_ov, bus.rsp_taken, bus.rsp_err};
        o.stable = bus.rsp_valid === 1'b1 && bus.req_ready === 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_data !== o.data ||
                {bus.rsp_zero, bus.rsp_ov, bus.rsp_taken, bus.rsp_err} !== o.fl)
                o.stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_opcode = '0;
        bus.req_funct = '0;
        bus.req_rs = '0;
        bus.req_rt = '0;
        bus.req_imm = '0;
        repeat (3) @(negedge clk);
        n_run++; if ({bus.alu_x, bus.alu_y, bus.alu_op} !== '0) begin n_fail++; $display("FAIL reset_alu: got %h %h %b want 0", bus.alu_x, bus.alu_y, bus.alu_op); end
        n_run++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.rsp_data); end
        n_run++; if ({bus.rsp_valid, bus.rsp_zero, bus.rsp_ov, bus.rsp_taken, bus.rsp_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.rsp_valid, bus.rsp_zero, bus.rsp_ov, bus.rsp_taken, bus.rsp_err}); end
        n_run++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h want 0000", ops_done); end
        n_run++; if (bus.alu_cin !== 1'b0) begin n_fail++; $display("FAIL reset_cin: got %b want 0", bus.alu_cin); end
        rst = 1'b0;
        @(negedge clk);
        n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        exp_x = '0; exp_y = '0; exp_op = '0; exp_cnt = '0;
    endtask

    task automatic test_add();
        obs_t o;
        run_op(6'h00, 6'h20, 16'h0003, 16'h0004, 16'h5A5A, 0, 1'b0, o);
        exp_x = 16'h0003; exp_y = 16'h0004; exp_op = 3'b000; exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.rdy !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", o.rdy); end
        n_run++; if (o.aop !== 3'b000 || o.ax !== 16'h0003 || o.ay !== 16'h0004) begin n_fail++; $display("FAIL add_operands: got %b %h %h want 000 0003 0004", o.aop, o.ax, o.ay); end
        n_run++; if (o.lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", o.lat); end
        n_run++; if (o.data !== 16'h0007) begin n_fail++; $display("FAIL add_data: got %h want 0007", o.data); end
        n_run++; if (o.fl !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b want 0000", o.fl); end
        n_run++; if (ops_done !== 16'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", ops_done); end
        n_run++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_beq();
        obs_t o;
        run_op(6'h04, 6'h2A, 16'h1234, 16'h1234, 16'h00FF, 0, 1'b0, o);
        exp_x = 16'h1234; exp_y = 16'h1234; exp_op = 3'b100; exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.aop !== 3'b100 || o.ay !== 16'h1234) begin n_fail++; $display("FAIL beq_operands: got %b %h want 100 1234", o.aop, o.ay); end
        n_run++; if (o.data !== 16'h0000) begin n_fail++; $display("FAIL beq_data: got %h want 0000", o.data); end
        n_run++; if (o.fl !== 4'b1010) begin n_fail++; $display("FAIL beq_flags: got %b want 1010", o.fl); end
        n_run++; if (ops_done !== exp_cnt) begin n_fail++; $display("FAIL beq_count: got %0d want %0d", ops_done, exp_cnt); end
    endtask

    task automatic test_overflow();
        obs_t o;
        run_op(6'h08, 6'h00, 16'h7FFF, 16'h1111, 16'h0001, 0, 1'b0, o);
        exp_x = 16'h7FFF; exp_y = 16'h0001; exp_op = 3'b000; exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.ay !== 16'h0001) begin n_fail++; $display("FAIL addi_imm: got %h want 0001", o.ay); end
        n_run++; if (o.data !== 16'h8000) begin n_fail++; $display("FAIL addi_data: got %h want 8000", o.data); end
        n_run++; if (o.fl !== 4'b0101) begin n_fail++; $display("FAIL addi_flags: got %b want 0101", o.fl); end
        run_op(6'h0D, 6'h00, 16'h7FFF, 16'h1111, 16'h0001, 0, 1'b0, o);
        exp_op = 3'b010; exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.aop !== 3'b010) begin n_fail++; $display("FAIL ori_op: got %b want 010", o.aop); end
        n_run++; if (o.data !== 16'h7FFF) begin n_fail++; $display("FAIL ori_data: got %h want 7FFF", o.data); end
        n_run++; if (o.fl !== 4'b0000) begin n_fail++; $display("FAIL ori_flags: got %b want 0000", o.fl); end
    endtask

    task automatic test_illegal();
        obs_t o;
        run_op(6'h3F, 6'h20, 16'hAAAA, 16'h5555, 16'h1234, 0, 1'b0, o);
        exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d want 1", o.lat); end
        n_run++; if (o.data !== 16'h0000) begin n_fail++; $display("FAIL illegal_data: got %h want 0000", o.data); end
        n_run++; if (o.fl !== 4'b0001) begin n_fail++; $display("FAIL illegal_flags: got %b want 0001", o.fl); end
        n_run++; if ({o.ax, o.ay, o.aop} !== {16'h7FFF, 16'h0001, 3'b010}) begin n_fail++; $display("FAIL illegal_alu_held: got %h %h %b want 7fff 0001 010", o.ax, o.ay, o.aop); end
        n_run++; if (ops_done !== exp_cnt) begin n_fail++; $display("FAIL illegal_count: got %0d want %0d", ops_done, exp_cnt); end
    endtask

    task automatic test_backpressure_reset();
        obs_t o;
        ref_t e;
        logic [W-1:0] rs, rt;
        logic quiet;
        rs = pick(); rt = pick();
        e = ref_op(6'h00, 6'h22, rs, rt, 16'h0000);
        run_op(6'h00, 6'h22, rs, rt, 16'h0000, 5, 1'b0, o);
        exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", o.stable); end
        n_run++; if (o.data !== e.data || o.fl !== e.fl) begin n_fail++; $display("FAIL bp_response: got %h %b want %h %b", o.data, o.fl, e.data, e.fl); end
        n_run++; if (ops_done !== exp_cnt) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", ops_done, exp_cnt); end
        bus.req_valid = 1'b1;
        bus.req_opcode = 6'h00;
        bus.req_funct = 6'h20;
        bus.req_rs = pick();
        bus.req_rt = pick();
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_run++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_busy: got ready=%b valid=%b want 0 0", bus.req_ready, bus.rsp_valid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_x = '0; exp_y = '0; exp_op = '0; exp_cnt = '0;
        n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b want 1", bus.req_ready); end
        n_run++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL midop_count: got %h want 0000", ops_done); end
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || ops_done !== 16'h0000) quiet = 1'b0;
        end
        n_run++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midop_no_response: got quiet=%b want 1", quiet); end
    endtask

    task automatic test_ignore();
        obs_t o;
        ref_t e;
        logic [W-1:0] rs, rt;
        rs = pick(); rt = pick();
        e = ref_op(6'h00, 6'h25, rs, rt, 16'h0000);
        run_op(6'h00, 6'h25, rs, rt, 16'h0000, 1, 1'b1, o);
        exp_x = rs; exp_y = rt; exp_op = 3'b010; exp_cnt = exp_cnt + 16'd1;
        n_run++; if (o.ax !== rs || o.ay !== rt) begin n_fail++; $display("FAIL ignore_operands: got %h %h want %h %h", o.ax, o.ay, rs, rt); end
        n_run++; if (o.data !== e.data) begin n_fail++; $display("FAIL ignore_data: got %h want %h", o.data, e.data); end
        n_run++; if (bus.alu_x !== rs) begin n_fail++; $display("FAIL ignore_alu_after: got %h want %h", bus.alu_x, rs); end
        n_run++; if (ops_done !== exp_cnt) begin n_fail++; $display("FAIL ignore_count: got %0d want %0d", ops_done, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] tbl [10] = '{12'h020, 12'h022, 12'h024, 12'h025, 12'h02A, 12'h200, 12'h300, 12'h340, 12'h280, 12'h100};
        logic [11:0] t;
        logic [5:0] opc, fn;
        logic [W-1:0] rs, rt, imm;
        ref_t e;
        obs_t o;
        for (int n = 0; n < 150; n++) begin
            t = tbl[$urandom_range(0, 9)];
            opc = t[11:6];
            fn = t[5:0];
            if (opc != 6'h00) fn = 6'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                opc = 6'($urandom);
                fn = 6'($urandom);
            end
            rs = pick();
            rt = $urandom_range(0, 3) == 0 ? rs : pick();
            imm = pick();
            e = ref_op(opc, fn, rs, rt, imm);
            run_op(opc, fn, rs, rt, imm, $urandom_range(0, 2), $urandom_range(0, 3) == 0, o);
            if (e.legal) begin
                exp_x = rs; exp_y = e.y; exp_op = e.op;
            end
            exp_cnt = exp_cnt + 16'd1;
            n_run++; if (o.rdy !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] ready: got %b want 1", n, o.rdy); end
            n_run++; if (o.lat !== (e.legal ? 3 : 1)) begin n_fail++; $display("FAIL b2b[%0d] latency op=%h fn=%h: got %0d want %0d", n, opc, fn, o.lat, e.legal ? 3 : 1); end
            n_run++; if ({o.ax, o.ay, o.aop} !== {exp_x, exp_y, exp_op}) begin n_fail++; $display("FAIL b2b[%0d] alu: got %h %h %b want %h %h %b", n, o.ax, o.ay, o.aop, exp_x, exp_y, exp_op); end
            n_run++; if (o.data !== e.data) begin n_fail++; $display("FAIL b2b[%0d] data op=%h fn=%h: got %h want %h", n, opc, fn, o.data, e.data); end
            n_run++; if (o.fl !== e.fl) begin n_fail++; $display("FAIL b2b[%0d] flags op=%h fn=%h: got %b want %b", n, opc, fn, o.fl, e.fl); end
            n_run++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] stable: got %b want 1", n, o.stable); end
            n_run++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b[%0d] valid_drop: got %b want 0", n, bus.rsp_valid); end
            n_run++; if (ops_done !== exp_cnt) begin n_fail++; $display("FAIL b2b[%0d] count: got %0d want %0d", n, ops_done, exp_cnt); end
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        force dut.ops_done_d = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.ops_done_d;
        n_run++; if (ops_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want FFFF", ops_done); end
        run_op(6'h3F, 6'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, o);
        n_run++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", ops_done); end
        run_op(6'h00, 6'h24, 16'hF0F0, 16'h0FF0, 16'h0000, 0, 1'b0, o);
        n_run++; if (ops_done !== 16'h0001 || o.data !== 16'h00F0) begin n_fail++; $display("FAIL wrap_next: got %h %h want 0001 00f0", ops_done, o.data); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_overflow();
        test_illegal();
        test_backpressure_reset();
        test_ignore();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
